iiitb_usr_deser: RTL and testbench



---
 rtl/iiitb_usr_deser.sv | 119 +++++++++++
 tb/tb_iiitb_usr_deser.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/iiitb_usr_deser.sv
// iiitb_usr_deser: serial-in/parallel-out receiver with a one-entry valid/ready output buffer.
// Define IIITB_USR_DESER_PARITY_EN to expect an even-parity bit after each word (perr pulses on error).
module iiitb_usr_deser #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       ctrl,
  input  logic             sin,
  output logic [WIDTH-1:0] pout,
  output logic             pvalid,
  input  logic             pready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  output logic             perr
);

  typedef enum logic [1:0] {
    C_HOLD  = 2'b00,
    C_LSB   = 2'b01,
    C_MSB   = 2'b10,
    C_CLEAR = 2'b11
  } ctrl_e;

  typedef enum logic {
    BUF_EMPTY,
    BUF_FULL
  } buf_e;

`ifdef IIITB_USR_DESER_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  buf_e             buf_q, buf_d;
  logic             overrun_q, overrun_d;
  logic             perr_q, perr_d;
  logic [WIDTH-1:0] word;
  logic             shift, done, good;

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    pout_d    = pout_q;
    buf_d     = buf_q;
    overrun_d = overrun_q;
    word      = sr_q;
    good      = 1'b1;
    shift     = (ctrl == C_LSB) || (ctrl == C_MSB);
    done      = shift && (cnt_q == CNT_W'(LAST));

    case (ctrl_e'(ctrl))
      C_MSB:   sr_d = {sr_q[WIDTH-2:0], sin};
      C_LSB:   sr_d = {sin, sr_q[WIDTH-1:1]};
      C_CLEAR: begin
        sr_d      = '0;
        cnt_d     = '0;
        overrun_d = 1'b0;
      end
      default: ;
    endcase
    if (shift) cnt_d = cnt_q + CNT_W'(1);

    // The parity cycle carries no data: the word is what was already in sr.
`ifdef IIITB_USR_DESER_PARITY_EN
    good = ~(^{sr_q, sin});
`else
    word = sr_d;
`endif
    if (done) begin
      sr_d  = '0;
      cnt_d = '0;
    end

    perr_d = done && !good;
    if (done && good) begin
      if ((buf_q == BUF_EMPTY) || pready) begin
        pout_d = word;
        buf_d  = BUF_FULL;
      end else begin
        overrun_d = 1'b1;
      end
    end else if ((buf_q == BUF_FULL) && pready) begin
      buf_d = BUF_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      pout_q    <= '0;
      buf_q     <= BUF_EMPTY;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      pout_q    <= pout_d;
      buf_q     <= buf_d;
      overrun_q <= overrun_d;
      perr_q    <= perr_d;
    end
  end

  assign pout    = pout_q;
  assign pvalid  = (buf_q == BUF_FULL);
  assign busy    = (cnt_q != '0);
  assign bit_cnt = cnt_q;
  assign overrun = overrun_q;
  assign perr    = perr_q;

endmodule

// File: tb/tb_iiitb_usr_deser.sv
// Testbench for iiitb_usr_deser: directed scenarios plus random traffic against a word-level model.
module tb_iiitb_usr_deser;
  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);
`ifdef IIITB_USR_DESER_PARITY_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    ctrl = 2'b00;
  logic          sin = 1'b0;
  logic          pready = 1'b0;
  logic [W-1:0]  pout;
  logic          pvalid, busy, overrun, perr;
  logic [CW-1:0] bit_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: the word is a plain integer and the buffer a valid flag.
  int m_sr, m_cnt, m_pout;
  bit m_pvalid, m_ovr, m_perr;

  iiitb_usr_deser #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl(ctrl), .sin(sin),
    .pout(pout), .pvalid(pvalid), .pready(pready), .busy(busy),
    .bit_cnt(bit_cnt), .overrun(overrun), .perr(perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] c, input logic s, input logic pr);
    bit done, good;
    int word, par;
    reset_n = r; ctrl = c; sin = s; pready = pr;
    @(posedge clk);
    m_perr = 0;
    if (!r) begin
      m_sr = 0; m_cnt = 0; m_pout = 0; m_pvalid = 0; m_ovr = 0;
    end else begin
      done = 0; good = 1; word = 0; par = 0;
      if (c == 2'b11) begin
        m_sr = 0; m_cnt = 0; m_ovr = 0;
      end else if (c != 2'b00) begin
        if (NBITS == W + 1 && m_cnt == W) par = int'(s);
        else if (c == 2'b10) m_sr = ((m_sr * 2) + int'(s)) % (1 << W);
        else m_sr = (m_sr / 2) + int'(s) * (1 << (W - 1));
        m_cnt++;
        if (m_cnt == NBITS) begin
          done = 1; word = m_sr;
          good = (NBITS == W) || ((($countones(m_sr) + par) % 2) == 0);
          m_sr = 0; m_cnt = 0;
        end
      end
      if (done && !good) m_perr = 1;
      if (done && good) begin
        if (!m_pvalid || pr) begin m_pout = word; m_pvalid = 1; end
        else m_ovr = 1;
      end else if (m_pvalid && pr) m_pvalid = 0;
    end
    #1;
    chk("pout", 32'(pout), 32'(m_pout));
    chk("pvalid", 32'(pvalid), 32'(m_pvalid));
    chk("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("perr", 32'(perr), 32'(m_perr));
  endtask

  // bits[W-1] is sent first; a correct even-parity bit follows when enabled.
  task automatic send(input logic [1:0] c, input logic [W-1:0] bits, input logic pr);
    for (int i = W - 1; i >= 0; i--) step(1'b1, c, bits[i], pr);
    if (NBITS == W + 1) step(1'b1, c, ^bits, pr);
  endtask

  initial begin
    m_sr = 0; m_cnt = 0; m_pout = 0; m_pvalid = 0; m_ovr = 0; m_perr = 0;

    // Reset with random control activity
    for (int i = 0; i < 2; i++) step(1'b0, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    chk("rst_pout", 32'(pout), 32'd0);
    chk("rst_pvalid", 32'(pvalid), 32'd0);

    // MSB-first word
    send(2'b10, 4'b1011, 1'b0);
    chk("msb_pout", 32'(pout), 32'hB);
    chk("msb_pvalid", 32'(pvalid), 32'd1);
    chk("msb_cnt", 32'(bit_cnt), 32'd0);
    step(1'b1, 2'b00, 1'b0, 1'b1);
    chk("msb_consumed", 32'(pvalid), 32'd0);

    // LSB-first word, then consume
    send(2'b01, 4'b1011, 1'b0);
    chk("lsb_pout", 32'(pout), 32'hD);
    step(1'b1, 2'b00, 1'b0, 1'b1);
    chk("lsb_consumed", 32'(pvalid), 32'd0);
    chk("lsb_pout_kept", 32'(pout), 32'hD);

    // Hold in the middle of a word
    step(1'b1, 2'b10, 1'b1, 1'b0);
    step(1'b1, 2'b10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b00, 1'($urandom), 1'b0);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_cnt", 32'(bit_cnt), 32'd2);
    end
    step(1'b1, 2'b10, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b0);
    if (NBITS == W + 1) step(1'b1, 2'b10, 1'b0, 1'b0);
    chk("hold_pout", 32'(pout), 32'hC);
    step(1'b1, 2'b00, 1'b0, 1'b1);

    // Backpressure and overrun
    send(2'b10, 4'b1010, 1'b0);
    send(2'b10, 4'b0110, 1'b0);
    chk("bp_pout", 32'(pout), 32'hA);
    chk("bp_ovr", 32'(overrun), 32'd1);
    step(1'b1, 2'b00, 1'b0, 1'b1);
    chk("bp_pvalid", 32'(pvalid), 32'd0);
    chk("bp_ovr_sticky", 32'(overrun), 32'd1);
    step(1'b1, 2'b11, 1'b0, 1'b0);
    chk("clr_ovr", 32'(overrun), 32'd0);

    // Clear a partial word
    step(1'b1, 2'b10, 1'b1, 1'b0);
    step(1'b1, 2'b01, 1'b1, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b0);
    chk("clr_cnt", 32'(bit_cnt), 32'd0);

    // Reset mid-word, then a clean word
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b1, 1'b0);
    step(1'b0, 2'b10, 1'b1, 1'b1);
    chk("rst2_cnt", 32'(bit_cnt), 32'd0);
    chk("rst2_pvalid", 32'(pvalid), 32'd0);
    send(2'b10, 4'b0101, 1'b0);
    chk("rst2_pout", 32'(pout), 32'h5);
    chk("rst2_pvalid1", 32'(pvalid), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [1:0] c;
      c = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      step(1'($urandom_range(0, 59) != 0), c, 1'($urandom), 1'($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
